// File: rtl/dly_wmemi_arb.sv
// Two-port WMEMI arbiter: lets two DelayWorker-class masters share one WMEMI
// memory slave. Command and write-data access is granted round-robin, one
// whole burst at a time. Read responses are steered back to the issuing port
// through an in-order tag FIFO that records which port owns each read burst.
module dly_wmemi_arb #(
  parameter int ADDR_WIDTH = 36,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                      wciS0_Clk,
  input  logic                      wciS0_MReset_n,

  // Slave port S0 (toward worker 0)
  input  logic [2:0]                wmemiS0_MCmd,
  input  logic [ADDR_WIDTH-1:0]     wmemiS0_MAddr,
  input  logic [11:0]               wmemiS0_MBurstLength,
  input  logic                      wmemiS0_MDataValid,
  input  logic                      wmemiS0_MDataLast,
  input  logic [DATA_WIDTH-1:0]     wmemiS0_MData,
  input  logic [DATA_WIDTH/8-1:0]   wmemiS0_MDataByteEn,
  output logic                      wmemiS0_SCmdAccept,
  output logic                      wmemiS0_SDataAccept,
  output logic [1:0]                wmemiS0_SResp,
  output logic                      wmemiS0_SRespLast,
  output logic [DATA_WIDTH-1:0]     wmemiS0_SData,

  // Slave port S1 (toward worker 1)
  input  logic [2:0]                wmemiS1_MCmd,
  input  logic [ADDR_WIDTH-1:0]     wmemiS1_MAddr,
  input  logic [11:0]               wmemiS1_MBurstLength,
  input  logic                      wmemiS1_MDataValid,
  input  logic                      wmemiS1_MDataLast,
  input  logic [DATA_WIDTH-1:0]     wmemiS1_MData,
  input  logic [DATA_WIDTH/8-1:0]   wmemiS1_MDataByteEn,
  output logic                      wmemiS1_SCmdAccept,
  output logic                      wmemiS1_SDataAccept,
  output logic [1:0]                wmemiS1_SResp,
  output logic                      wmemiS1_SRespLast,
  output logic [DATA_WIDTH-1:0]     wmemiS1_SData,

  // Master port M0 (toward memory controller)
  output logic [2:0]                wmemiM0_MCmd,
  output logic [ADDR_WIDTH-1:0]     wmemiM0_MAddr,
  output logic [11:0]               wmemiM0_MBurstLength,
  output logic                      wmemiM0_MDataValid,
  output logic                      wmemiM0_MDataLast,
  output logic [DATA_WIDTH-1:0]     wmemiM0_MData,
  output logic [DATA_WIDTH/8-1:0]   wmemiM0_MDataByteEn,
  input  logic                      wmemiM0_SCmdAccept,
  input  logic                      wmemiM0_SDataAccept,
  input  logic [1:0]                wmemiM0_SResp,
  input  logic                      wmemiM0_SRespLast,
  input  logic [DATA_WIDTH-1:0]     wmemiM0_SData,

  output logic                      arb_err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = $clog2(TAG_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_READ = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2
  } state_t;

  state_t r_state;
  logic   r_grant;       // 0 = S0, 1 = S1
  logic   r_last_grant;  // port that won the most recent arbitration

  // Slave-side request fields gathered into two-entry arrays for muxing
  logic [2:0]            w_mcmd   [2];
  logic [ADDR_WIDTH-1:0] w_maddr  [2];
  logic [11:0]           w_mlen   [2];
  logic                  w_mdv    [2];
  logic                  w_mdl    [2];
  logic [DATA_WIDTH-1:0] w_mdata  [2];
  logic [BE_WIDTH-1:0]   w_mbe    [2];

  assign w_mcmd[0]  = wmemiS0_MCmd;
  assign w_mcmd[1]  = wmemiS1_MCmd;
  assign w_maddr[0] = wmemiS0_MAddr;
  assign w_maddr[1] = wmemiS1_MAddr;
  assign w_mlen[0]  = wmemiS0_MBurstLength;
  assign w_mlen[1]  = wmemiS1_MBurstLength;
  assign w_mdv[0]   = wmemiS0_MDataValid;
  assign w_mdv[1]   = wmemiS1_MDataValid;
  assign w_mdl[0]   = wmemiS0_MDataLast;
  assign w_mdl[1]   = wmemiS1_MDataLast;
  assign w_mdata[0] = wmemiS0_MData;
  assign w_mdata[1] = wmemiS1_MData;
  assign w_mbe[0]   = wmemiS0_MDataByteEn;
  assign w_mbe[1]   = wmemiS1_MDataByteEn;

  // Tag FIFO state
  logic [TAG_DEPTH-1:0] r_tag_mem;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_arb_err;

  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_push;
  logic w_pop;
  logic w_resp_any;
  logic w_resp_ok;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_tag_mem[r_rd_ptr];

  // Granted-port view of the request
  logic [2:0] w_g_cmd;
  logic       w_g_dv;
  logic       w_g_dl;

  assign w_g_cmd = w_mcmd[r_grant];
  assign w_g_dv  = w_mdv[r_grant];
  assign w_g_dl  = w_mdl[r_grant];

  // A read may only be granted while there is room to record its tag;
  // the full check uses the registered count, so a same-cycle pop does not help.
  logic w_elig0;
  logic w_elig1;
  logic w_pick;

  assign w_elig0 = (w_mcmd[0] != CMD_IDLE) && ((w_mcmd[0] != CMD_READ) || !w_full);
  assign w_elig1 = (w_mcmd[1] != CMD_IDLE) && ((w_mcmd[1] != CMD_READ) || !w_full);
  assign w_pick  = (w_elig0 && w_elig1) ? ~r_last_grant : w_elig1;

  assign w_push = (r_state == ST_CMD) && wmemiM0_SCmdAccept &&
                  (w_g_cmd == CMD_READ) && !w_full;

  assign w_resp_any = (wmemiM0_SResp != 2'd0);
  assign w_resp_ok  = w_resp_any && !w_empty;
  assign w_pop      = w_resp_ok && wmemiM0_SRespLast;

  // Burst-level arbitration FSM: pick a port, carry its command, then its write data
  always_ff @(posedge wciS0_Clk or negedge wciS0_MReset_n) begin
    if (!wciS0_MReset_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      unique case (r_state)
        ST_IDLE: begin
          if (w_elig0 || w_elig1) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (wmemiM0_SCmdAccept) begin
            r_state <= (w_g_cmd == CMD_READ) ? ST_IDLE : ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_g_dv && wmemiM0_SDataAccept && w_g_dl) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy; push on read accept, pop on last response beat
  always_ff @(posedge wciS0_Clk or negedge wciS0_MReset_n) begin
    if (!wciS0_MReset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage: records which port issued each outstanding read burst
  always_ff @(posedge wciS0_Clk) begin
    // NOTE: storage is deliberately not reset; entries are only read while
    // r_count says they are valid, so reset values would be dead logic.
    if (w_push) r_tag_mem[r_wr_ptr] <= r_grant;
  end

  // Sticky error: a response beat arrived with no read outstanding
  always_ff @(posedge wciS0_Clk or negedge wciS0_MReset_n) begin
    if (!wciS0_MReset_n) begin
      r_arb_err <= 1'b0;
    end else if (w_resp_any && w_empty) begin
      r_arb_err <= 1'b1;
    end
  end

  assign arb_err = r_arb_err;

  // Command/data muxing toward memory and accept routing back to the granted port
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    wmemiM0_MCmd         = CMD_IDLE;
    wmemiM0_MAddr        = '0;
    wmemiM0_MBurstLength = '0;
    wmemiM0_MDataValid   = 1'b0;
    wmemiM0_MDataLast    = 1'b0;
    wmemiM0_MData        = '0;
    wmemiM0_MDataByteEn  = '0;
    wmemiS0_SCmdAccept   = 1'b0;
    wmemiS1_SCmdAccept   = 1'b0;
    wmemiS0_SDataAccept  = 1'b0;
    wmemiS1_SDataAccept  = 1'b0;
    unique case (r_state)
      ST_CMD: begin
        wmemiM0_MCmd         = w_g_cmd;
        wmemiM0_MAddr        = w_maddr[r_grant];
        wmemiM0_MBurstLength = w_mlen[r_grant];
        if (r_grant) wmemiS1_SCmdAccept = wmemiM0_SCmdAccept;
        else         wmemiS0_SCmdAccept = wmemiM0_SCmdAccept;
      end
      ST_WDATA: begin
        wmemiM0_MDataValid  = w_g_dv;
        wmemiM0_MDataLast   = w_g_dl;
        wmemiM0_MData       = w_mdata[r_grant];
        wmemiM0_MDataByteEn = w_mbe[r_grant];
        if (r_grant) wmemiS1_SDataAccept = wmemiM0_SDataAccept;
        else         wmemiS0_SDataAccept = wmemiM0_SDataAccept;
      end
      default: ;
    endcase
  end

  // Response steering: zero-latency routing to the port at the FIFO head
  assign wmemiS0_SResp     = (w_resp_ok && !w_head) ? wmemiM0_SResp     : 2'd0;
  assign wmemiS0_SRespLast = (w_resp_ok && !w_head) ? wmemiM0_SRespLast : 1'b0;
  assign wmemiS1_SResp     = (w_resp_ok &&  w_head) ? wmemiM0_SResp     : 2'd0;
  assign wmemiS1_SRespLast = (w_resp_ok &&  w_head) ? wmemiM0_SRespLast : 1'b0;

  // Read data is broadcast; SResp qualifies it per port
  assign wmemiS0_SData = wmemiM0_SData;
  assign wmemiS1_SData = wmemiM0_SData;

endmodule

// File: tb/tb_dly_wmemi_arb.sv
// Directed testbench for dly_wmemi_arb: the bench plays both workers and the
// memory controller, and checks every step against hand-computed values.
module tb_dly_wmemi_arb;

  localparam int AW = 36;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rst_n;

  logic [2:0]    s0_cmd, s1_cmd;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [11:0]   s0_len, s1_len;
  logic          s0_dv, s1_dv, s0_dl, s1_dl;
  logic [DW-1:0] s0_data, s1_data;
  logic [BW-1:0] s0_be, s1_be;
  logic          s0_scmdacc, s1_scmdacc, s0_sdacc, s1_sdacc;
  logic [1:0]    s0_sresp, s1_sresp;
  logic          s0_slast, s1_slast;
  logic [DW-1:0] s0_sdata, s1_sdata;

  logic [2:0]    m0_mcmd;
  logic [AW-1:0] m0_maddr;
  logic [11:0]   m0_mlen;
  logic          m0_mdv, m0_mdl;
  logic [DW-1:0] m0_mdata;
  logic [BW-1:0] m0_mbe;
  logic          m0_scmdacc, m0_sdacc;
  logic [1:0]    m0_sresp;
  logic          m0_slast;
  logic [DW-1:0] m0_sdata;
  logic          arb_err;

  int n_chk = 0;
  int n_err = 0;

  dly_wmemi_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(4)) dut (
    .wciS0_Clk            (clk),
    .wciS0_MReset_n       (rst_n),
    .wmemiS0_MCmd         (s0_cmd),
    .wmemiS0_MAddr        (s0_addr),
    .wmemiS0_MBurstLength (s0_len),
    .wmemiS0_MDataValid   (s0_dv),
    .wmemiS0_MDataLast    (s0_dl),
    .wmemiS0_MData        (s0_data),
    .wmemiS0_MDataByteEn  (s0_be),
    .wmemiS0_SCmdAccept   (s0_scmdacc),
    .wmemiS0_SDataAccept  (s0_sdacc),
    .wmemiS0_SResp        (s0_sresp),
    .wmemiS0_SRespLast    (s0_slast),
    .wmemiS0_SData        (s0_sdata),
    .wmemiS1_MCmd         (s1_cmd),
    .wmemiS1_MAddr        (s1_addr),
    .wmemiS1_MBurstLength (s1_len),
    .wmemiS1_MDataValid   (s1_dv),
    .wmemiS1_MDataLast    (s1_dl),
    .wmemiS1_MData        (s1_data),
    .wmemiS1_MDataByteEn  (s1_be),
    .wmemiS1_SCmdAccept   (s1_scmdacc),
    .wmemiS1_SDataAccept  (s1_sdacc),
    .wmemiS1_SResp        (s1_sresp),
    .wmemiS1_SRespLast    (s1_slast),
    .wmemiS1_SData        (s1_sdata),
    .wmemiM0_MCmd         (m0_mcmd),
    .wmemiM0_MAddr        (m0_maddr),
    .wmemiM0_MBurstLength (m0_mlen),
    .wmemiM0_MDataValid   (m0_mdv),
    .wmemiM0_MDataLast    (m0_mdl),
    .wmemiM0_MData        (m0_mdata),
    .wmemiM0_MDataByteEn  (m0_mbe),
    .wmemiM0_SCmdAccept   (m0_scmdacc),
    .wmemiM0_SDataAccept  (m0_sdacc),
    .wmemiM0_SResp        (m0_sresp),
    .wmemiM0_SRespLast    (m0_slast),
    .wmemiM0_SData        (m0_sdata),
    .arb_err              (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: advance past the rising edge so registered state has settled
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int n_g;
  int n_acc;
  int exp_port [6] = '{1, 1, 1, 1, 0, 0};
  int exp_last [6] = '{0, 1, 1, 1, 0, 1};

  initial begin
    rst_n = 1'b0;
    s0_cmd = '0; s0_addr = '0; s0_len = '0; s0_dv = 1'b0; s0_dl = 1'b0; s0_data = '0; s0_be = '1;
    s1_cmd = '0; s1_addr = '0; s1_len = '0; s1_dv = 1'b0; s1_dl = 1'b0; s1_data = '0; s1_be = '1;
    m0_scmdacc = 1'b1; m0_sdacc = 1'b1; m0_sresp = '0; m0_slast = 1'b0; m0_sdata = '0;

    // Reset state
    #12;
    chk("rst_mcmd",     m0_mcmd, 0);
    chk("rst_mdv",      m0_mdv, 0);
    chk("rst_maddr",    m0_maddr, 0);
    chk("rst_s0_cacc",  s0_scmdacc, 0);
    chk("rst_s1_dacc",  s1_sdacc, 0);
    chk("rst_err",      arb_err, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // Single read from S0, length 4, address 0x100
    s0_cmd = 3'd2; s0_addr = 'h100; s0_len = 12'd4;
    #1;
    chk("t1_idle_mcmd", m0_mcmd, 0);
    cyc();
    chk("t1_mcmd",      m0_mcmd, 2);
    chk("t1_maddr",     m0_maddr, 'h100);
    chk("t1_mlen",      m0_mlen, 4);
    chk("t1_s0_cacc",   s0_scmdacc, 1);
    chk("t1_s1_cacc",   s1_scmdacc, 0);
    cyc();
    s0_cmd = '0;
    #1;
    chk("t1_post_mcmd", m0_mcmd, 0);
    for (int i = 0; i < 4; i++) begin
      m0_sresp = 2'd1; m0_slast = (i == 3); m0_sdata = 128'hA0 + 128'(i);
      #1;
      chk("t1_s0_resp",  s0_sresp, 1);
      chk("t1_s1_resp",  s1_sresp, 0);
      chk("t1_s0_last",  s0_slast, (i == 3));
      chk("t1_s1_sdata", s1_sdata, 128'hA0 + 128'(i));
      cyc();
    end
    m0_sresp = '0; m0_slast = 1'b0;
    #1;
    chk("t1_err", arb_err, 0);

    // Fresh reset so S0 wins the first tie
    rst_n = 1'b0;
    #1;
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // Contention: both write length 2 in the same cycle
    s0_cmd = 3'd1; s0_addr = 'h200; s0_len = 12'd2;
    s1_cmd = 3'd1; s1_addr = 'h300; s1_len = 12'd2;
    cyc();
    chk("t2_mcmd0",     m0_mcmd, 1);
    chk("t2_maddr0",    m0_maddr, 'h200);
    chk("t2_s0_cacc",   s0_scmdacc, 1);
    chk("t2_s1_cacc",   s1_scmdacc, 0);
    s0_cmd = '0; s0_dv = 1'b1; s0_dl = 1'b0; s0_data = 'h11;
    #1;
    chk("t2_cmd_no_dv", m0_mdv, 0);
    cyc();
    chk("t2_dv",        m0_mdv, 1);
    chk("t2_data0",     m0_mdata, 'h11);
    chk("t2_s0_dacc",   s0_sdacc, 1);
    chk("t2_s1_dacc",   s1_sdacc, 0);
    chk("t2_wd_mcmd",   m0_mcmd, 0);
    s0_dl = 1'b1; s0_data = 'h22;
    #1;
    chk("t2_data1",     m0_mdata, 'h22);
    chk("t2_dlast",     m0_mdl, 1);
    cyc();
    s0_dv = 1'b0; s0_dl = 1'b0;
    #1;
    chk("t2_idle_dv",   m0_mdv, 0);
    chk("t2_idle_dl",   m0_mdl, 0);
    cyc();
    chk("t2_mcmd1",     m0_mcmd, 1);
    chk("t2_maddr1",    m0_maddr, 'h300);
    chk("t2_s1_cacc1",  s1_scmdacc, 1);
    chk("t2_s0_cacc1",  s0_scmdacc, 0);
    s1_cmd = '0; s1_dv = 1'b1; s1_dl = 1'b0; s1_data = 'h33;
    cyc();
    chk("t2_data2",     m0_mdata, 'h33);
    chk("t2_s1_dacc1",  s1_sdacc, 1);
    chk("t2_s0_dacc1",  s0_sdacc, 0);
    s1_dl = 1'b1; s1_data = 'h44;
    #1;
    chk("t2_data3",     m0_mdata, 'h44);
    cyc();
    s1_dv = 1'b0; s1_dl = 1'b0;

    // Round-robin: both ports request single-beat writes continuously
    s0_cmd = 3'd1; s0_addr = 'h400; s0_len = 12'd1; s0_dv = 1'b1; s0_dl = 1'b1; s0_data = 'h55;
    s1_cmd = 3'd1; s1_addr = 'h500; s1_len = 12'd1; s1_dv = 1'b1; s1_dl = 1'b1; s1_data = 'h66;
    n_g = 0;
    for (int c = 0; c < 40 && n_g < 8; c++) begin
      cyc();
      if (m0_mcmd != 3'd0) begin
        chk("t3_grant",   s1_scmdacc, (n_g % 2));
        chk("t3_one_acc", s0_scmdacc ^ s1_scmdacc, 1);
        chk("t3_addr",    m0_maddr, (n_g % 2) ? 'h500 : 'h400);
        n_g++;
      end
    end
    chk("t3_count", n_g, 8);
    cyc();
    s0_cmd = '0; s1_cmd = '0;
    cyc();
    s0_dv = 1'b0; s0_dl = 1'b0; s1_dv = 1'b0; s1_dl = 1'b0;
    #1;
    chk("t3_end_mcmd", m0_mcmd, 0);

    // Tag full: four reads from S1 with no responses yet
    s1_cmd = 3'd2; s1_addr = 'h700; s1_len = 12'd1;
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 4; c++) begin
      cyc();
      if (s1_scmdacc) n_acc++;
    end
    chk("t4_acc_count", n_acc, 4);
    cyc();
    s1_cmd = '0;
    s0_cmd = 3'd2; s0_addr = 'h600; s0_len = 12'd1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("t4_blocked_mcmd", m0_mcmd, 0);
      chk("t4_blocked_acc",  s0_scmdacc, 0);
    end
    m0_sresp = 2'd1; m0_slast = 1'b1; m0_sdata = 'hB0;
    #1;
    chk("t4_first_s1", s1_sresp, 1);
    chk("t4_first_s0", s0_sresp, 0);
    cyc();
    m0_sresp = '0; m0_slast = 1'b0;
    #1;
    chk("t4_pop_edge_mcmd", m0_mcmd, 0);
    cyc();
    chk("t4_s0_mcmd",  m0_mcmd, 2);
    chk("t4_s0_addr",  m0_maddr, 'h600);
    chk("t4_s0_acc",   s0_scmdacc, 1);
    cyc();
    s0_cmd = '0;
    for (int i = 0; i < 6; i++) begin
      m0_sresp = 2'd1; m0_slast = exp_last[i][0];
      #1;
      chk("t4_order_s0", s0_sresp, (exp_port[i] == 0) ? 1 : 0);
      chk("t4_order_s1", s1_sresp, (exp_port[i] == 1) ? 1 : 0);
      cyc();
    end
    m0_sresp = '0; m0_slast = 1'b0;
    #1;
    chk("t4_err", arb_err, 0);

    // Backpressure: command held off for 5 cycles
    m0_scmdacc = 1'b0;
    s0_cmd = 3'd1; s0_addr = 'h800; s0_len = 12'd1;
    cyc();
    s1_cmd = 3'd1; s1_addr = 'h900; s1_len = 12'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_mcmd",    m0_mcmd, 1);
      chk("t5_addr",    m0_maddr, 'h800);
      chk("t5_s0_cacc", s0_scmdacc, 0);
      chk("t5_s1_cacc", s1_scmdacc, 0);
      cyc();
    end
    m0_scmdacc = 1'b1;
    #1;
    chk("t5_rel_s0", s0_scmdacc, 1);
    chk("t5_rel_s1", s1_scmdacc, 0);
    cyc();
    s0_cmd = '0; s1_cmd = '0; s0_dv = 1'b1; s0_dl = 1'b1; s0_data = 'h77;
    #1;
    chk("t5_s0_dacc", s0_sdacc, 1);
    chk("t5_data",    m0_mdata, 'h77);
    cyc();
    s0_dv = 1'b0; s0_dl = 1'b0;

    // Spurious response with no read outstanding
    m0_sresp = 2'd1; m0_slast = 1'b1;
    #1;
    chk("t6_s0_resp", s0_sresp, 0);
    chk("t6_s1_resp", s1_sresp, 0);
    cyc();
    m0_sresp = '0; m0_slast = 1'b0;
    #1;
    chk("t6_err_set",  arb_err, 1);
    cyc();
    chk("t6_err_held", arb_err, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_err_clr",  arb_err, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
